// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter between NUM_REQ requesters.
// Define UART_ARB_LOCK_EN to add req_lock, which lets a requester hold priority across bytes.
module uart_tx_arbiter #(
  parameter int NUM_REQ      = 4,
  parameter int DATA_W       = 8,
  parameter int BUSY_TIMEOUT = 16
) (
  input  logic                      clk_50MHZ,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
`ifdef UART_ARB_LOCK_EN
  input  logic [NUM_REQ-1:0]        req_lock,
`endif
  output logic [NUM_REQ-1:0]        gnt,
  output logic [NUM_REQ-1:0]        done,
  output logic [DATA_W-1:0]         uart_data,
  output logic                      uart_tx_start,
  input  logic                      uart_tx_busy,
  output logic                      arb_busy,
  output logic                      err_timeout
);

  localparam int PTR_W = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(BUSY_TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, START, WAIT_BUSY, WAIT_DONE} state_t;

  state_t              state_q, state_d;
  logic [PTR_W-1:0]    ptr_q, ptr_d;
  logic [PTR_W-1:0]    idx_q, idx_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [NUM_REQ-1:0]  gnt_q, gnt_d;
  logic [NUM_REQ-1:0]  done_q, done_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic                start_q, start_d;
  logic                abusy_q, abusy_d;
  logic                err_q, err_d;

  logic                pick_vld;
  logic [PTR_W-1:0]    pick_idx;
  logic [PTR_W-1:0]    done_ptr;
  int                  scan_j;

  // First pending request after the last-grant pointer, wrapping around.
  always_comb begin
    pick_vld = 1'b0;
    pick_idx = '0;
    scan_j   = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      scan_j = int'(ptr_q) + k;
      if (scan_j >= NUM_REQ) scan_j = scan_j - NUM_REQ;
      if (!pick_vld && req[PTR_W'(scan_j)]) begin
        pick_vld = 1'b1;
        pick_idx = PTR_W'(scan_j);
      end
    end
  end

  always_comb begin
    done_ptr = idx_q;
`ifdef UART_ARB_LOCK_EN
    // Parking the pointer just behind i keeps i first in line for its next byte.
    if (req_lock[idx_q] && req[idx_q])
      done_ptr = (idx_q == '0) ? PTR_W'(NUM_REQ - 1) : idx_q - PTR_W'(1);
`endif
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    gnt_d   = gnt_q;
    done_d  = '0;
    data_d  = data_q;
    start_d = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      IDLE: begin
        // A reset mid-frame can leave the UART still shifting; hold off until it is idle.
        if (!uart_tx_busy && pick_vld) begin
          idx_d           = pick_idx;
          gnt_d           = '0;
          gnt_d[pick_idx] = 1'b1;
          data_d          = req_data[pick_idx*DATA_W +: DATA_W];
          start_d         = 1'b1;
          state_d         = START;
        end
      end
      START: begin
        cnt_d   = '0;
        state_d = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        if (uart_tx_busy) begin
          state_d = WAIT_DONE;
        end else if (cnt_q == CNT_W'(BUSY_TIMEOUT - 2)) begin
          // Registered pulse lands exactly BUSY_TIMEOUT cycles after tx_start.
          err_d         = 1'b1;
          done_d[idx_q] = 1'b1;
          gnt_d         = '0;
          ptr_d         = done_ptr;
          state_d       = IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      WAIT_DONE: begin
        if (!uart_tx_busy) begin
          done_d[idx_q] = 1'b1;
          gnt_d         = '0;
          ptr_d         = done_ptr;
          state_d       = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    abusy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk_50MHZ) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= PTR_W'(NUM_REQ - 1);
      idx_q   <= '0;
      cnt_q   <= '0;
      gnt_q   <= '0;
      done_q  <= '0;
      data_q  <= '0;
      start_q <= 1'b0;
      abusy_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      gnt_q   <= gnt_d;
      done_q  <= done_d;
      data_q  <= data_d;
      start_q <= start_d;
      abusy_q <= abusy_d;
      err_q   <= err_d;
    end
  end

  assign gnt           = gnt_q;
  assign done          = done_q;
  assign uart_data     = data_q;
  assign uart_tx_start = start_q;
  assign arb_busy      = abusy_q;
  assign err_timeout   = err_q;

endmodule
